// File: rtl/transmit_dac.sv
// Serial DAC transmitter: single-entry hold buffer feeding a 16-bit SYNC-framed, MSB-first shifter.
// Latency: sample accepted at edge E drives dac_sync low after E+1; back-to-back period 32*CLK_DIV+GAP_CYCLES.
// Backpressure: tx_ready is low while the hold buffer is full; tx_start is silently ignored then.
module transmit_dac #(
    parameter int DATA_W     = 12,
    parameter int FRAME_W    = 16,
    parameter int CLK_DIV    = 2,
    parameter int GAP_CYCLES = 2
) (
    input  logic              sclk,
    input  logic              rst,
    input  logic              tx_start,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [1:0]        pd_mode,
    output logic              tx_ready,
    output logic              tx_done_tick,
    output logic              dac_sclk,
    output logic              dac_sync,
    output logic              dac_sdata
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int BIT_W = $clog2(FRAME_W + 1);
    localparam int PAD_W = FRAME_W - DATA_W - 2;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    logic [1:0]         state;
    logic [FRAME_W-1:0] hold;
    logic               hold_valid;
    logic [FRAME_W-1:0] shifter;
    logic [DIV_W-1:0]   div_cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic [BIT_W-1:0]   bit_cnt;
    logic [FRAME_W-1:0] new_frame;
    logic               accept;
    logic               load_now;

    assign new_frame = {{PAD_W{1'b0}}, pd_mode, tx_data};
    assign accept    = tx_start & tx_ready;
    // LOAD has no state of its own: it is the edge leaving IDLE, or the last GAP edge, with a full hold buffer.
    assign load_now  = hold_valid & ((state == ST_IDLE) | ((state == ST_GAP) & (gap_cnt == GAP_LAST)));

    // Frame sequencer: hold buffer, sclk divider, bit shifter and registered DAC pins.
    always_ff @(posedge sclk) begin
        if (!rst) begin
            state        <= ST_IDLE;
            hold         <= '0;
            hold_valid   <= 1'b0;
            tx_ready     <= 1'b1;
            shifter      <= '0;
            div_cnt      <= '0;
            gap_cnt      <= '0;
            bit_cnt      <= '0;
            tx_done_tick <= 1'b0;
            dac_sclk     <= 1'b1;
            dac_sync     <= 1'b1;
            dac_sdata    <= 1'b0;
        end else begin
            tx_done_tick <= 1'b0;

            // tx_ready mirrors ~hold_valid, so accept and load can never hit the same edge.
            if (accept) begin
                hold       <= new_frame;
                hold_valid <= 1'b1;
                tx_ready   <= 1'b0;
            end

            if (load_now) begin
                hold_valid <= 1'b0;
                tx_ready   <= 1'b1;
                // MSB goes straight to the pin; the shifter keeps the remaining bits MSB-aligned.
                dac_sdata  <= hold[FRAME_W-1];
                shifter    <= {hold[FRAME_W-2:0], 1'b0};
                dac_sync   <= 1'b0;
                dac_sclk   <= 1'b1;
                div_cnt    <= '0;
                bit_cnt    <= '0;
                state      <= ST_SHIFT;
            end else begin
                case (state)
                    ST_SHIFT: begin
                        if (div_cnt == DIV_LAST) begin
                            div_cnt <= '0;
                            if (dac_sclk) begin
                                // Falling edge: the DAC latches the bit currently on dac_sdata.
                                dac_sclk <= 1'b0;
                                if (bit_cnt != BIT_LAST) begin
                                    bit_cnt <= bit_cnt + BIT_W'(1);
                                end
                            end else begin
                                dac_sclk <= 1'b1;
                                if (bit_cnt == BIT_LAST) begin
                                    // Rise after the last fall closes the frame; it is the first gap cycle.
                                    dac_sync     <= 1'b1;
                                    dac_sdata    <= 1'b0;
                                    tx_done_tick <= 1'b1;
                                    gap_cnt      <= '0;
                                    state        <= ST_GAP;
                                end else begin
                                    dac_sdata <= shifter[FRAME_W-1];
                                    shifter   <= {shifter[FRAME_W-2:0], 1'b0};
                                end
                            end
                        end else begin
                            div_cnt <= div_cnt + DIV_W'(1);
                        end
                    end
                    ST_GAP: begin
                        if (gap_cnt == GAP_LAST) begin
                            state <= ST_IDLE;
                        end else begin
                            gap_cnt <= gap_cnt + GAP_W'(1);
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_transmit_dac.sv
// Self-checking bench for transmit_dac: directed vector table, multi-cycle corner sequences, random frames.
// A negedge monitor reconstructs frames from the DAC pins; expectations come from the frame-format rules.
// Every bounded wait reports FAIL on expiry and still reaches the summary line.
module tb_transmit_dac;
    localparam int CLK_DIV    = 2;
    localparam int GAP_CYCLES = 2;
    localparam int LOW_CYC    = 32 * CLK_DIV;
    localparam int N_RAND     = 24;

    logic        sclk     = 1'b0;
    logic        rst      = 1'b0;
    logic        tx_start = 1'b0;
    logic [11:0] tx_data  = 12'h000;
    logic [1:0]  pd_mode  = 2'b00;
    logic        tx_ready;
    logic        tx_done_tick;
    logic        dac_sclk;
    logic        dac_sync;
    logic        dac_sdata;

    transmit_dac #(
        .DATA_W(12), .FRAME_W(16), .CLK_DIV(CLK_DIV), .GAP_CYCLES(GAP_CYCLES)
    ) dut (
        .sclk(sclk), .rst(rst), .tx_start(tx_start), .tx_data(tx_data), .pd_mode(pd_mode),
        .tx_ready(tx_ready), .tx_done_tick(tx_done_tick),
        .dac_sclk(dac_sclk), .dac_sync(dac_sync), .dac_sdata(dac_sdata)
    );

    always #5 sclk = ~sclk;

    typedef struct {
        logic [15:0] bits;
        int          n;
        int          low;
        logic        done;
    } frm_t;

    typedef struct {
        logic [11:0] data;
        logic [1:0]  pd;
        logic [15:0] frame;
    } vec_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_done = 0;

    // Pin-level monitor state
    logic        prev_sck   = 1'b1;
    logic        prev_sync  = 1'b1;
    logic [15:0] cur_bits   = 16'h0;
    int          cur_n      = 0;
    int          cur_low    = 0;
    int          high_cnt   = 0;
    bit          seen_frame = 1'b0;
    int          done_total = 0;
    int          sdata_viol = 0;
    int          idle_viol  = 0;
    int          min_gap    = 100000;
    frm_t        frames[$];
    int          gaps[$];
    logic [15:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reconstruct frames from the pins: bits taken on dac_sclk falls while dac_sync is low.
    always @(negedge sclk) begin
        if (dac_sync === 1'b0) begin
            if (prev_sync && seen_frame) begin
                gaps.push_back(high_cnt);
                if (high_cnt < min_gap) min_gap = high_cnt;
            end
            cur_low++;
            if (prev_sck === 1'b1 && dac_sclk === 1'b0) begin
                cur_bits = {cur_bits[14:0], dac_sdata};
                cur_n++;
            end
        end else begin
            if (prev_sync === 1'b0) begin
                frames.push_back('{bits: cur_bits, n: cur_n, low: cur_low, done: tx_done_tick});
                cur_bits   = 16'h0;
                cur_n      = 0;
                cur_low    = 0;
                high_cnt   = 0;
                seen_frame = 1'b1;
            end
            high_cnt++;
            if (dac_sdata !== 1'b0) sdata_viol++;
            if (dac_sclk !== 1'b1) idle_viol++;
        end
        if (tx_done_tick === 1'b1) done_total++;
        prev_sck  = dac_sclk;
        prev_sync = dac_sync;
    end

    task automatic send(input logic [11:0] d, input logic [1:0] p);
        int t;
        t = 0;
        @(negedge sclk);
        while (tx_ready !== 1'b1 && t < 2000) begin
            @(negedge sclk);
            t++;
        end
        chk("ready_wait", t < 2000, 1);
        tx_data  = d;
        pd_mode  = p;
        tx_start = 1'b1;
        @(negedge sclk);
        tx_start = 1'b0;
    endtask

    task automatic wait_frames(input int n, input int budget);
        int t;
        t = 0;
        while (frames.size() < n && t < budget) begin
            @(negedge sclk);
            #1;
            t++;
        end
        chk("frame_wait", frames.size() >= n, 1);
    endtask

    task automatic check_frame(input string tag, input logic [15:0] exp);
        frm_t f;
        exp_done++;
        chk({tag, "_present"}, frames.size() > 0, 1);
        if (frames.size() > 0) begin
            f = frames.pop_front();
            chk({tag, "_bits"}, f.bits, exp);
            chk({tag, "_nbits"}, f.n, 16);
            chk({tag, "_sync_low"}, f.low, LOW_CYC);
            chk({tag, "_done"}, f.done, 1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[5];
        frm_t        f;
        logic [11:0] d;
        logic [1:0]  p;
        int          t;
        int          idle;

        vecs[0] = '{data: 12'h000, pd: 2'b11, frame: 16'h3000};
        vecs[1] = '{data: 12'h800, pd: 2'b00, frame: 16'h0800};
        vecs[2] = '{data: 12'h555, pd: 2'b01, frame: 16'h1555};
        vecs[3] = '{data: 12'hAAA, pd: 2'b10, frame: 16'h2AAA};
        vecs[4] = '{data: 12'hFFF, pd: 2'b11, frame: 16'h3FFF};

        // Reset values
        rst = 1'b0;
        repeat (3) @(negedge sclk);
        chk("rst_sync", dac_sync, 1);
        chk("rst_sclk", dac_sclk, 1);
        chk("rst_sdata", dac_sdata, 0);
        chk("rst_ready", tx_ready, 1);
        chk("rst_done", tx_done_tick, 0);
        rst = 1'b1;
        repeat (2) @(negedge sclk);

        // First-frame latency and content
        tx_data = 12'hA5C; pd_mode = 2'b00; tx_start = 1'b1;
        @(negedge sclk);
        tx_start = 1'b0;
        chk("lat_ready_low", tx_ready, 0);
        chk("lat_sync_e", dac_sync, 1);
        @(negedge sclk);
        chk("lat_sync_e1", dac_sync, 0);
        chk("lat_ready_back", tx_ready, 1);
        chk("lat_sdata_msb", dac_sdata, 0);
        chk("lat_sclk_high", dac_sclk, 1);
        wait_frames(1, 200);
        check_frame("a5c", 16'h0A5C);

        // Vector table
        for (int i = 0; i < 5; i++) begin
            send(vecs[i].data, vecs[i].pd);
            wait_frames(1, 300);
            check_frame($sformatf("vec%0d", i), vecs[i].frame);
        end

        // Back-to-back: second word accepted as soon as tx_ready returns
        send(12'hFFF, 2'b00);
        send(12'h001, 2'b00);
        wait_frames(2, 400);
        check_frame("b2b_first", 16'h0FFF);
        check_frame("b2b_second", 16'h0001);
        chk("b2b_gap_present", gaps.size() > 0, 1);
        if (gaps.size() > 0) chk("b2b_gap", gaps[gaps.size()-1], GAP_CYCLES);

        // tx_start while tx_ready is low is dropped
        send(12'h456, 2'b00);
        tx_data = 12'h123; pd_mode = 2'b00; tx_start = 1'b1;
        @(negedge sclk);
        tx_start = 1'b0;
        wait_frames(1, 300);
        check_frame("ignore_kept", 16'h0456);
        repeat (150) @(negedge sclk);
        chk("ignore_no_extra", frames.size(), 0);

        // Reset after the 7th falling edge aborts the frame
        send(12'h7A3, 2'b00);
        t = 0;
        while (!(dac_sync === 1'b0 && cur_n == 7) && t < 500) begin
            @(negedge sclk);
            #1;
            t++;
        end
        chk("abort_reach7", cur_n, 7);
        rst = 1'b0;
        @(negedge sclk);
        chk("abort_sync", dac_sync, 1);
        chk("abort_done", tx_done_tick, 0);
        chk("abort_sclk", dac_sclk, 1);
        chk("abort_sdata", dac_sdata, 0);
        chk("abort_ready", tx_ready, 1);
        #1;
        rst = 1'b1;
        chk("abort_rec", frames.size(), 1);
        if (frames.size() > 0) begin
            f = frames.pop_front();
            chk("abort_nbits", f.n, 7);
            chk("abort_rec_done", f.done, 0);
        end
        send(12'h800, 2'b00);
        wait_frames(1, 300);
        check_frame("after_abort", 16'h0800);

        // Random frames, mixing back-to-back and idle spacing
        for (int i = 0; i < N_RAND; i++) begin
            d = 12'($urandom_range(0, 4095));
            p = 2'($urandom_range(0, 3));
            idle = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 80)) : 0;
            repeat (idle) @(negedge sclk);
            send(d, p);
            exp_q.push_back(16'((int'(p) << 12) + int'(d)));
        end
        wait_frames(N_RAND, N_RAND * 200);
        while (exp_q.size() > 0) check_frame("rand", exp_q.pop_front());

        repeat (10) @(negedge sclk);
        chk("done_tick_total", done_total, exp_done);
        chk("sdata_zero_when_sync_high", sdata_viol, 0);
        chk("no_sclk_edges_outside_frame", idle_viol, 0);
        chk("min_gap", min_gap, GAP_CYCLES);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
